// File: rtl/rx_buffer.sv
// Serial receiver: start / 8 data LSB-first / optional even parity / stop,
// feeding a small first-word-fall-through FIFO popped by rx_buff_rd.
module rx_buffer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       rx_buff_rd,
  output logic [7:0] data_out,
  output logic       rx_buff_empty,
  output logic       rx_buff_full,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic          r_sync1, r_sync2;
  logic [1:0]    r_flush;
  logic          r_armed;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_par_bad;
  logic          r_frame_err, r_parity_err, r_overrun;
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          r_empty, r_full;
  logic [7:0]    r_mem [FIFO_DEPTH];

  logic          w_line;
  logic          w_tick_half, w_tick_full;
  logic          w_stop_sample, w_push_req, w_push, w_pop;
  logic [AW:0]   w_wr_next, w_rd_next;

  assign w_line        = r_sync2;
  assign w_tick_half   = (r_cnt == HALF_M1);
  assign w_tick_full   = (r_cnt == FULL_M1);
  assign w_stop_sample = (r_state == S_STOP) && w_tick_full;
  assign w_push_req    = w_stop_sample && w_line && !r_par_bad;
  assign w_pop         = rx_buff_rd && !r_empty;
  // A pop on the same edge frees the slot a full FIFO needs for the push.
  assign w_push        = w_push_req && (!r_full || rx_buff_rd);
  assign w_wr_next     = r_wr_ptr + (AW + 1)'(w_push);
  assign w_rd_next     = r_rd_ptr + (AW + 1)'(w_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  // Arming waits until the synchronizer holds a genuine post-reset pin sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flush <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      if (r_flush != 2'd2) r_flush <= r_flush + 2'd1;
      if (w_stop_sample && !w_line)          r_armed <= 1'b0;
      else if (r_flush == 2'd2 && w_line)    r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_par_bad <= 1'b0;
          if (r_armed && !w_line) r_state <= S_START;
        end
        S_START: begin
          if (w_tick_half) begin
            r_cnt   <= '0;
            r_state <= w_line ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick_full) begin
            r_cnt   <= '0;
            r_shift <= {w_line, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
              r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_tick_full) begin
            r_cnt     <= '0;
            r_par_bad <= ^{r_shift, w_line};
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick_full) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Error pulses are mutually exclusive by construction: frame > parity > overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
    end else begin
      r_frame_err  <= w_stop_sample && !w_line;
      r_parity_err <= w_stop_sample && w_line && r_par_bad;
      r_overrun    <= w_push_req && r_full && !rx_buff_rd;
      r_wr_ptr     <= w_wr_next;
      r_rd_ptr     <= w_rd_next;
      r_empty      <= (w_wr_next == w_rd_next);
      r_full       <= (w_wr_next[AW] != w_rd_next[AW]) &&
                      (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);
    end
  end

  // NOTE: storage has no reset; stale entries are unreachable while the
  // pointers say empty, and data_out is forced to zero in that case.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  assign data_out      = r_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign rx_buff_empty = r_empty;
  assign rx_buff_full  = r_full;
  assign frame_err     = r_frame_err;
  assign parity_err    = r_parity_err;
  assign overrun       = r_overrun;

endmodule

// File: doc/rx_buffer.md
# rx_buffer

Receive-side counterpart of the transmitter buffer. Deserializes the asynchronous serial frame produced by the transmitter: start bit, 8 data bits LSB first, optional even parity, and stop bit. Good bytes are pushed into a small receive FIFO, and the downstream consumer pops them with a read strobe. The block sits between the serial line and the byte-level consumer, and mirrors the transmitter's data_in / tx_buff_ld load interface on the read side.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be even and ≥4.
- FIFO_DEPTH, 4: receive FIFO entries. Must be a power of 2 and ≥2.
- PARITY_EN, 1: 1 means an even-parity bit sits between data and stop; 0 means no parity bit.
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- serial_in  input  1  serial line, idle high, asynchronous to clk
- rx_buff_rd  input  1  pop strobe, one byte per cycle asserted; ignored when empty
- data_out  output  8  FIFO head byte (first-word fall-through), valid while rx_buff_empty=0
- rx_buff_empty  output  1  FIFO holds no bytes
- rx_buff_full  output  1  FIFO holds FIFO_DEPTH bytes
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- parity_err  output  1  one-cycle pulse: parity mismatch with a good stop bit
- overrun  output  1  one-cycle pulse: good byte dropped because the FIFO was full

## Operation
- serial_in passes through a 2-flop synchronizer; both flops reset to 1. All references to "line" below mean the synchronizer output.
- Arming: after reset release, the receiver ignores the line until it has been sampled high once. This prevents a false start if reset drops mid-frame.
- FSM states: IDLE, START, DATA, PARITY, STOP. Bit-timing counter and bit index are cleared on every state entry.
- IDLE: armed and line=0 → START.
- START: at mid-bit, line=1 → IDLE (glitch, nothing reported); line=0 → DATA.
- DATA: samples 8 bits, one per CLKS_PER_BIT, shifting LSB first into an 8-bit shift register. After bit 7 → PARITY if PARITY_EN, else STOP.
- PARITY: samples the parity bit. Even parity means the XOR of the 8 data bits and the parity bit must be 0. The result is latched → STOP.
- STOP sample, line=0: frame_err pulses, byte discarded, → IDLE. Armed clears; the line must be seen high before the next start is accepted.
- STOP sample, line=1 but parity bad: parity_err pulses, byte discarded, → IDLE.
- STOP sample, line=1 and parity good (or PARITY_EN=0): byte pushed, → IDLE.
- Push when full: byte dropped and overrun pulses. Exception: if rx_buff_rd is asserted that same cycle, the pop frees a slot, the push is accepted, and overrun stays 0.
- Only one error pulse per frame. Priority: frame_err > parity_err > overrun.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits. Empty when pointers are equal; full when the MSBs differ and the remaining bits are equal. Pointers wrap naturally.
- Simultaneous push and pop when not empty: both happen and occupancy is unchanged. Pop on empty: ignored, no pointer change.
- data_out shows the FIFO head; its value is don't-care when empty.

## Timing
- Reset values: data_out=0x00, rx_buff_empty=1, rx_buff_full=0, frame_err=0, parity_err=0, overrun=0, FSM=IDLE, unarmed, FIFO emptied. Reset mid-frame discards the partial byte and all stored bytes.
- Synchronizer latency is 2 cycles. Let T be the edge at which IDLE sees line=0.
- Start is sampled at T+CLKS_PER_BIT/2.
- Data bit n (0..7) is sampled at T+CLKS_PER_BIT/2+(n+1)·CLKS_PER_BIT.
- Parity is sampled at T+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- Stop is sampled at T+CLKS_PER_BIT/2+(9+PARITY_EN)·CLKS_PER_BIT.
- On the stop-sample edge: the push occurs and the error pulses assert. rx_buff_empty falls and data_out is valid on the same edge. The FSM re-enters IDLE and can detect a new start on the next cycle.
- Pop: a rising edge with rx_buff_rd=1 and not empty advances the head. data_out shows the next byte after that edge.
- rx_buff_full and rx_buff_empty are registered and reflect occupancy after each edge.

## Test plan
- Reset then single frame: CLKS_PER_BIT=16, PARITY_EN=1, send 0xAA with parity 0 and stop 1. Required: rx_buff_empty falls exactly 170 cycles after the line falling edge at the serial_in pin (2 sync + 8 + 10·16), data_out=0xAA, no error pulses.
- Burst 0xAA, 0x55, 0xCC, 0xF0, 0x01 (parity 1) back-to-back with no reads, FIFO_DEPTH=4. Required: rx_buff_full=1 after the 4th byte; the 5th byte pulses overrun; popping returns 0xAA, 0x55, 0xCC, 0xF0, then empty=1.
- Error frames: 0x55 sent with parity 1 → parity_err pulse, FIFO unchanged. 0xCC sent with stop 0 → frame_err only (no parity_err). The next frame is accepted only after the line returns high.
- Glitch: serial_in low for 4 cycles in IDLE. Required: START aborts to IDLE, no push, no error pulses.
- Full plus simultaneous pop: with the FIFO full, assert rx_buff_rd on the stop-sample edge of a 0x3C frame. Required: no overrun, full stays 1, and 0x3C is read last after 3 more pops.
- Reset mid-frame: assert reset during DATA bit 4 and release while the line is still low. Required: all outputs at reset values, no start detected until the line goes high, and the next full frame 0xF0 is received correctly.
